// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game-level sequencing for breakout.
// Runs the newgame/play/newball/over state machine from the hit/miss pulses,
// the frame tick and the key input. Keeps the 2-digit BCD score and the
// remaining-ball count, and freezes the graph engine outside of play.
// Optional build macro HIGH_SCORE_EN: tracks the best score since reset on
// hi1:hi0. Without it, hi1:hi0 are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// NEWGAME  | waiting for a key press; score 00, full ball count
// PLAY     | ball in motion; hit scores, miss costs a ball
// NEWBALL  | hold after a miss; relaunch on key once hold time is over
// OVER     | game-over screen held for OVER_TICKS, then back to NEWGAME

module breakout_game_ctrl #(
  parameter int BALLS         = 3,
  parameter int NEWBALL_TICKS = 30,
  parameter int OVER_TICKS    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_any,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] state,
  output logic       gra_still,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic [3:0] hi0,
  output logic [3:0] hi1
);

  localparam int MAX_TICKS = (NEWBALL_TICKS > OVER_TICKS) ? NEWBALL_TICKS : OVER_TICKS;
  localparam int TW        = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

  localparam logic [TW-1:0] NEWBALL_LOAD = TW'(NEWBALL_TICKS);
  localparam logic [TW-1:0] OVER_LOAD    = TW'(OVER_TICKS);
  localparam logic [1:0]    BALLS_INIT   = 2'(BALLS);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          gra_still_q, gra_still_d;
  logic [3:0]    dig0_q, dig0_d;
  logic [3:0]    dig1_q, dig1_d;
  logic [1:0]    ball_q, ball_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          key_d_q;

  logic          start;
  logic          expired;
  logic          timer_load;
  logic [TW-1:0] timer_load_val;
  logic [3:0]    inc0, inc1;

  assign start   = key_any & ~key_d_q;
  assign expired = (timer_q == '0);

  // Saturating BCD increment of the current score.
  always_comb begin
    inc0 = dig0_q;
    inc1 = dig1_q;
    if (dig1_q == 4'd9 && dig0_q == 4'd9) begin
      inc0 = dig0_q;
      inc1 = dig1_q;
    end else if (dig0_q == 4'd9) begin
      inc0 = 4'd0;
      inc1 = dig1_q + 4'd1;
    end else begin
      inc0 = dig0_q + 4'd1;
    end
  end

  // Next-state, score, ball and timer-load decisions.
  always_comb begin
    state_d        = state_q;
    dig0_d         = dig0_q;
    dig1_d         = dig1_q;
    ball_d         = ball_q;
    timer_load     = 1'b0;
    timer_load_val = '0;

    unique case (state_q)
      S_NEWGAME: begin
        dig0_d = 4'd0;
        dig1_d = 4'd0;
        ball_d = BALLS_INIT;
        if (start) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit) begin
          dig0_d = inc0;
          dig1_d = inc1;
        end
        if (miss) begin
          timer_load = 1'b1;
          if (ball_q == 2'd1) begin
            ball_d         = 2'd0;
            timer_load_val = OVER_LOAD;
            state_d        = S_OVER;
          end else begin
            ball_d         = ball_q - 2'd1;
            timer_load_val = NEWBALL_LOAD;
            state_d        = S_NEWBALL;
          end
        end
      end
      S_NEWBALL: begin
        if (start && expired) state_d = S_PLAY;
      end
      S_OVER: begin
        if (expired) begin
          dig0_d  = 4'd0;
          dig1_d  = 4'd0;
          ball_d  = BALLS_INIT;
          state_d = S_NEWGAME;
        end
      end
      default: state_d = S_NEWGAME;
    endcase

    gra_still_d = (state_d != S_PLAY);
  end

  // Hold timer: a load takes priority over a coincident frame tick.
  always_comb begin
    timer_d = timer_q;
    if (timer_load)
      timer_d = timer_load_val;
    else if (frame_tick && !expired)
      timer_d = timer_q - TW'(1);
  end

  // Game state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_NEWGAME;
      gra_still_q <= 1'b1;
      dig0_q      <= 4'd0;
      dig1_q      <= 4'd0;
      ball_q      <= BALLS_INIT;
      timer_q     <= '0;
      key_d_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gra_still_q <= gra_still_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      ball_q      <= ball_d;
      timer_q     <= timer_d;
      key_d_q     <= key_any;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [3:0] hi0_q, hi0_d;
  logic [3:0] hi1_q, hi1_d;

  // Capture a strictly better final score as the game ends.
  always_comb begin
    hi0_d = hi0_q;
    hi1_d = hi1_q;
    if (state_q == S_PLAY && state_d == S_OVER &&
        {dig1_d, dig0_d} > {hi1_q, hi0_q}) begin
      hi0_d = dig0_d;
      hi1_d = dig1_d;
    end
  end

  // High-score registers; only a reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi0_q <= 4'd0;
      hi1_q <= 4'd0;
    end else begin
      hi0_q <= hi0_d;
      hi1_q <= hi1_d;
    end
  end

  assign hi0 = hi0_q;
  assign hi1 = hi1_q;
`else
  assign hi0 = 4'd0;
  assign hi1 = 4'd0;
`endif

  assign state     = state_q;
  assign gra_still = gra_still_q;
  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign ball      = ball_q;

endmodule
